// File: rtl/turn_state_sequencer.sv
// Two-player turn sequencer producing the 4-bit game state word.
// Optional per-turn timeout enabled by defining TURN_TIMEOUT_EN.
module turn_state_sequencer #(
  parameter int ROUNDS  = 3,
  parameter int ROUND_W = 2,
  parameter int TIMEOUT = 15,
  parameter int TIMER_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               p1_btn,
  input  logic               p2_btn,
  output logic [3:0]         state,
  output logic [ROUND_W-1:0] round_cnt,
  output logic               p1_ack,
  output logic               p2_ack,
  output logic               done
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'b0000,
    S_DEAL      = 4'b0001,
    S_P1_TURN   = 4'b0010,
    S_P1_HANDED = 4'b0011,
    S_P2_HANDED = 4'b0100,
    S_P2_TURN   = 4'b0101,
    S_SCORE     = 4'b0110,
    S_GAME_OVER = 4'b1000
  } state_e;

  localparam logic [ROUND_W-1:0] RMAX = ROUND_W'(ROUNDS);

  state_e             state_q, state_d;
  logic [ROUND_W-1:0] rnd_q, rnd_d;
  logic [ROUND_W-1:0] rnd_inc;
  logic               p1_ack_q, p1_ack_d;
  logic               p2_ack_q, p2_ack_d;
  logic               start_q, p1_q, p2_q;
  logic               start_rise, p1_rise, p2_rise;
  logic               tmo;

  assign start_rise = start & ~start_q;
  assign p1_rise    = p1_btn & ~p1_q;
  assign p2_rise    = p2_btn & ~p2_q;
  assign rnd_inc    = rnd_q + 1'b1;

`ifdef TURN_TIMEOUT_EN
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               in_turn;

  assign in_turn = (state_q == S_P1_TURN) ||
                   (state_q == S_P2_TURN);
  assign tmo     = timer_q == TIMER_W'(TIMEOUT - 1);

  // Timer restarts whenever a turn state is (re)entered.
  always_comb begin
    timer_d = '0;
    if (in_turn && (state_d == state_q)) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT, TIMER_W};
  assign tmo        = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    rnd_d    = rnd_q;
    p1_ack_d = 1'b0;
    p2_ack_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_rise) state_d = S_DEAL;
      end
      S_DEAL: begin
        rnd_d   = '0;
        state_d = S_P1_TURN;
      end
      S_P1_TURN: begin
        if (p1_rise) begin
          state_d  = S_P1_HANDED;
          p1_ack_d = 1'b1;
        end else if (tmo) begin
          state_d = S_P1_HANDED;
        end
      end
      S_P1_HANDED: begin
        state_d = S_P2_TURN;
      end
      S_P2_TURN: begin
        if (p2_rise) begin
          state_d  = S_P2_HANDED;
          p2_ack_d = 1'b1;
        end else if (tmo) begin
          state_d = S_P2_HANDED;
        end
      end
      S_P2_HANDED: begin
        if (rnd_q != RMAX) rnd_d = rnd_inc;
        if (rnd_inc == RMAX || rnd_q == RMAX) begin
          state_d = S_SCORE;
        end else begin
          state_d = S_P1_TURN;
        end
      end
      S_SCORE: begin
        state_d = S_GAME_OVER;
      end
      S_GAME_OVER: begin
        if (start_rise) state_d = S_DEAL;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rnd_q    <= '0;
      p1_ack_q <= 1'b0;
      p2_ack_q <= 1'b0;
      start_q  <= 1'b0;
      p1_q     <= 1'b0;
      p2_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rnd_q    <= rnd_d;
      p1_ack_q <= p1_ack_d;
      p2_ack_q <= p2_ack_d;
      start_q  <= start;
      p1_q     <= p1_btn;
      p2_q     <= p2_btn;
    end
  end

  assign state     = state_q;
  assign round_cnt = rnd_q;
  assign p1_ack    = p1_ack_q;
  assign p2_ack    = p2_ack_q;
  assign done      = (state_q == S_GAME_OVER);

endmodule

// File: doc/turn_state_sequencer.md
Name: turn_state_sequencer

Overview:
- Generates the 4-bit game state word that the handed-flag trackers and the display logic decode.
- Sequences a two-player, turn-based round: deal, P1 turn, hand-off to P2, P2 turn, hand-off back to P1, and repeats for ROUNDS rounds before scoring.
- Consumes raw player buttons and emits the state codes that set and clear the handed flags.

Parameters:
ROUNDS, 3, number of full P1+P2 rounds per game (1..2^ROUND_W-1)
ROUND_W, 2, width of round counter
TIMEOUT, 15, cycles allowed per turn before forced hand-off (only with TURN_TIMEOUT_EN)
TIMER_W, 4, width of turn timer

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; forces IDLE
start  input  1  level; rising edge starts a game from IDLE or GAME_OVER
p1_btn  input  1  P1 action button, level (synchronised upstream)
p2_btn  input  1  P2 action button, level
state  output  4  current state code, registered
round_cnt  output  ROUND_W  completed rounds
p1_ack  output  1  one-cycle pulse when a P1 press is accepted
p2_ack  output  1  one-cycle pulse when a P2 press is accepted
done  output  1  high while in GAME_OVER

Behaviour:
- Fixed state codes:
  - IDLE=0000, DEAL=0001, P1_TURN=0010, P1_HANDED=0011, P2_HANDED=0100, P2_TURN=0101, SCORE=0110, GAME_OVER=1000.
  - DEAL clears both handed flags. P1_HANDED sets the P1 flag. P2_HANDED sets the P2 flag.
  - state[2:0] values 001/011/100 appear only in these three states. No other state may produce them, including transient codes.
- Reset (async): state=0000, round_cnt=0, p1_ack=0, p2_ack=0, done=0, edge-detect registers=0, timer=0.
- Edge detect: press = btn & ~btn_q. Registers are updated every cycle.
- Transitions (one per clock):
  - IDLE: start rise -> DEAL.
  - DEAL: -> P1_TURN (1 cycle). round_cnt<=0.
  - P1_TURN: p1 press -> P1_HANDED, p1_ack=1 for that cycle. p2 presses are ignored and not acked.
  - P1_HANDED: -> P2_TURN (exactly 1 cycle).
  - P2_TURN: p2 press -> P2_HANDED, p2_ack=1. p1 presses are ignored.
  - P2_HANDED: round_cnt<=round_cnt+1. If round_cnt+1==ROUNDS -> SCORE, else -> P1_TURN.
  - SCORE: -> GAME_OVER (1 cycle).
  - GAME_OVER: done=1. start rise -> DEAL. Holds otherwise.
- Latency: a press sampled on cycle N gives ack and the HANDED code on the state output at cycle N+1.
- Simultaneous presses: only the current turn's player is accepted. Presses in non-turn states are dropped and not queued.
- A button held across a turn boundary does not re-trigger; a new rising edge is required.
- start rise in any state other than IDLE/GAME_OVER is ignored.
- round_cnt saturates at ROUNDS, never wraps. It holds its value in SCORE/GAME_OVER and is cleared only by DEAL or reset.
- Reset mid-game: immediate return to IDLE. Acks are deasserted the same instant.

Optional Feature:
- Macro TURN_TIMEOUT_EN.
- When defined:
  - TIMER_W-bit timer clears on entry to P1_TURN/P2_TURN and increments each cycle in those states.
  - When timer==TIMEOUT-1 with no press, transition proceeds as for a press (P1_HANDED or P2_HANDED) with no ack pulse.
  - A press on the timeout cycle wins and is acked.
- When undefined: no timer logic; turns wait indefinitely; the TIMEOUT/TIMER_W parameters are unused.

Test Plan:
- Reset then start pulse -> state 0000, 0001, 0010 on consecutive cycles; round_cnt=0, done=0.
- ROUNDS=3, alternate p1/p2 single-cycle presses -> state trace 0010,0011,0101,0100 repeated 3 times, then 0110, 1000. round_cnt ends at 3, done=1, six acks total.
- In P1_TURN assert p1_btn and p2_btn together -> only p1_ack. Holding p2_btn high into P2_TURN gives no transition until it drops and rises again.
- Assert reset asynchronously mid-P2_TURN with round_cnt=1 -> state 0000 and round_cnt 0 before the next clock edge. A start rise afterwards gives DEAL.
- With TURN_TIMEOUT_EN, TIMEOUT=15, no presses -> P1_TURN lasts 15 cycles then 0011 with p1_ack=0. A press on cycle 15 yields p1_ack=1.
- In GAME_OVER, start rise -> 0001 then 0010, with round_cnt cleared to 0.
